// File: rtl/cache_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cache_arbiter
// Description : Shares one physical-memory port between the I-cache and the
//               D-cache. One requester is granted at a time. Ties alternate
//               between the two requesters. The granted command is forwarded
//               to memory and the memory response is routed back to it.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_arbiter #(
  parameter int addr_width = 32,
  parameter int line_width = 256
) (
  input  logic                  clk,
  input  logic                  reset,

  // Instruction cache
  input  logic                  i_read,
  input  logic [addr_width-1:0] i_address,
  output logic [line_width-1:0] i_rdata,
  output logic                  i_resp,

  // Data cache
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [addr_width-1:0] d_address,
  input  logic [line_width-1:0] d_wdata,
  output logic [line_width-1:0] d_rdata,
  output logic                  d_resp,

  // Physical memory
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [addr_width-1:0] pmem_address,
  output logic [line_width-1:0] pmem_wdata,
  input  logic [line_width-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  // last_grant encoding: 0 = I-cache, 1 = D-cache
  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  state_t state;
  state_t state_next;
  logic   last_grant;
  logic   last_grant_next;

  logic   pend_i;
  logic   pend_d;

  // A D request is a read, a write-back, or both; I only ever reads
  assign pend_i = i_read;
  assign pend_d = d_read | d_write;

  // Read data goes to both caches unconditionally; only the resp pulse qualifies it
  assign i_rdata = pmem_rdata;
  assign d_rdata = pmem_rdata;

  // State and fairness register; reset forces IDLE and makes D win the first tie
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= GRANT_I;
    end else begin
      state      <= state_next;
      last_grant <= last_grant_next;
    end
  end

  // Grant selection, transaction completion/abort, and command/response routing
  always_comb begin
    state_next      = state;
    last_grant_next = last_grant;
    pmem_read       = 1'b0;
    pmem_write      = 1'b0;
    pmem_address    = '0;
    pmem_wdata      = '0;
    i_resp          = 1'b0;
    d_resp          = 1'b0;

    case (state)
      IDLE: begin
        // No command is driven here and a stray pmem_resp is simply ignored
        if (pend_i && pend_d) begin
          // Tie: hand the port to whoever did not have it last
          if (last_grant == GRANT_I) begin
            state_next      = SERVE_D;
            last_grant_next = GRANT_D;
          end else begin
            state_next      = SERVE_I;
            last_grant_next = GRANT_I;
          end
        end else if (pend_i) begin
          state_next      = SERVE_I;
          last_grant_next = GRANT_I;
        end else if (pend_d) begin
          state_next      = SERVE_D;
          last_grant_next = GRANT_D;
        end
      end

      SERVE_I: begin
        pmem_read    = i_read;
        pmem_address = i_address;
        i_resp       = pmem_resp;
        // Completion, or the I-cache withdrew its request (abort, no resp)
        if (pmem_resp || !pend_i) begin
          state_next = IDLE;
        end
      end

      SERVE_D: begin
        // A write-back takes precedence when read and write are both raised
        pmem_write   = d_write;
        pmem_read    = d_read & ~d_write;
        pmem_address = d_address;
        pmem_wdata   = d_wdata;
        d_resp       = pmem_resp;
        if (pmem_resp || !pend_d) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_cache_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_arbiter
// Description : Self-checking bench for cache_arbiter. Directed scenarios
//               followed by randomized traffic, checked every cycle against a
//               behavioural model of the arbitration rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic         i_read;
  logic [31:0]  i_address;
  logic [255:0] i_rdata;
  logic         i_resp;
  logic         d_read;
  logic         d_write;
  logic [31:0]  d_address;
  logic [255:0] d_wdata;
  logic [255:0] d_rdata;
  logic         d_resp;
  logic         pmem_read;
  logic         pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;

  always #5 clk = ~clk;

  cache_arbiter #(
    .addr_width(32),
    .line_width(256)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .i_read      (i_read),
    .i_address   (i_address),
    .i_rdata     (i_rdata),
    .i_resp      (i_resp),
    .d_read      (d_read),
    .d_write     (d_write),
    .d_address   (d_address),
    .d_wdata     (d_wdata),
    .d_rdata     (d_rdata),
    .d_resp      (d_resp),
    .pmem_read   (pmem_read),
    .pmem_write  (pmem_write),
    .pmem_address(pmem_address),
    .pmem_wdata  (pmem_wdata),
    .pmem_rdata  (pmem_rdata),
    .pmem_resp   (pmem_resp)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the memory port (0 none, 1 I, 2 D) and whether D won last
  int owner   = 0;
  bit last_d  = 1'b0;
  bit i_done  = 1'b0;
  bit d_done  = 1'b0;
  int mem_wait = -1;

  // Observations used by directed scenarios
  int          i_pulses = 0;
  int          d_pulses = 0;
  bit          prev_cmd = 1'b0;
  logic [31:0] grant_q[$];

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom();
    return v;
  endfunction

  // Does the model expect a memory command to be on the bus this cycle?
  function automatic bit cmd_expected();
    if (reset) return 1'b0;
    if (owner == 1) return i_read;
    if (owner == 2) return d_read || d_write;
    return 1'b0;
  endfunction

  // Memory responder: answers lat cycles after a command first appears
  task automatic drive_mem(input int lat_lo, input int lat_hi, input bit stray);
    pmem_resp = 1'b0;
    if (cmd_expected()) begin
      if (mem_wait < 0) mem_wait = $urandom_range(lat_hi, lat_lo);
      if (mem_wait == 0) begin
        pmem_resp  = 1'b1;
        pmem_rdata = rand_line();
        mem_wait   = -1;
      end else begin
        mem_wait--;
      end
    end else begin
      mem_wait = -1;
      if (stray && !reset && owner == 0 && $urandom_range(7, 0) == 0) pmem_resp = 1'b1;
    end
  endtask

  // Let combinational outputs settle, then compare every output to the model
  task automatic settle_check();
    logic        e_rd, e_wr, e_ir, e_dr;
    logic [31:0] e_addr;
    logic [255:0] e_wd;
    #1;
    e_rd = 1'b0; e_wr = 1'b0; e_ir = 1'b0; e_dr = 1'b0; e_addr = '0; e_wd = '0;
    if (!reset && owner == 1) begin
      e_rd   = i_read;
      e_addr = i_address;
      e_ir   = pmem_resp;
    end
    if (!reset && owner == 2) begin
      e_wr   = d_write;
      e_rd   = d_read && !d_write;
      e_addr = d_address;
      e_wd   = d_wdata;
      e_dr   = pmem_resp;
    end
    check_eq("pmem_read",    pmem_read,    e_rd);
    check_eq("pmem_write",   pmem_write,   e_wr);
    check_eq("pmem_address", pmem_address, e_addr);
    check_eq("pmem_wdata",   pmem_wdata,   e_wd);
    check_eq("i_resp",       i_resp,       e_ir);
    check_eq("d_resp",       d_resp,       e_dr);
    check_eq("i_rdata",      i_rdata,      pmem_rdata);
    check_eq("d_rdata",      d_rdata,      pmem_rdata);
    if (i_resp) i_pulses++;
    if (d_resp) d_pulses++;
    if ((pmem_read || pmem_write) && !prev_cmd) grant_q.push_back(pmem_address);
    prev_cmd = pmem_read || pmem_write;
  endtask

  // Apply the arbitration rules for the coming clock edge, then move to it
  task automatic advance();
    bit want_i, want_d;
    i_done = 1'b0;
    d_done = 1'b0;
    if (reset) begin
      owner  = 0;
      last_d = 1'b0;
    end else if (owner == 0) begin
      want_i = i_read;
      want_d = d_read || d_write;
      if (want_i && want_d) owner = last_d ? 1 : 2;
      else if (want_i)      owner = 1;
      else if (want_d)      owner = 2;
      if (owner != 0) last_d = (owner == 2);
    end else if (owner == 1) begin
      i_done = pmem_resp;
      if (pmem_resp || !i_read) owner = 0;
    end else begin
      d_done = pmem_resp;
      if (pmem_resp || !(d_read || d_write)) owner = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input int lat);
    drive_mem(lat, lat, 1'b0);
    settle_check();
    advance();
  endtask

  task automatic quiet_inputs();
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    i_address = '0; d_address = '0; d_wdata = '0;
  endtask

  task automatic rand_inputs();
    int k;
    if (i_read && (i_done || (owner == 1 && $urandom_range(29, 0) == 0))) begin
      i_read = 1'b0;
    end else if (!i_read && $urandom_range(2, 0) == 0) begin
      i_read = 1'b1;
      i_address = $urandom();
    end else if (owner != 1 && $urandom_range(3, 0) == 0) begin
      i_address = $urandom();
    end
    if ((d_read || d_write) && (d_done || (owner == 2 && $urandom_range(29, 0) == 0))) begin
      d_read = 1'b0;
      d_write = 1'b0;
    end else if (!(d_read || d_write) && $urandom_range(2, 0) == 0) begin
      k = $urandom_range(2, 0);
      d_read = (k != 1);
      d_write = (k != 0);
      d_address = $urandom();
      d_wdata = rand_line();
    end else if (owner != 2 && $urandom_range(3, 0) == 0) begin
      d_address = $urandom();
      d_wdata = rand_line();
    end
  endtask

  initial begin
    quiet_inputs();
    pmem_rdata = '0;
    pmem_resp  = 1'b0;
    reset      = 1'b1;
    @(posedge clk);
    #1;

    // Reset state
    drive_mem(1, 1, 1'b0);
    settle_check();
    check_eq("rst_cmd", {pmem_read, pmem_write, i_resp, d_resp}, 4'b0000);
    check_eq("rst_addr", pmem_address, 32'h0);
    advance();

    // Single I read at 0x40 with a 3-cycle memory
    reset = 1'b0;
    i_pulses = 0; d_pulses = 0;
    i_read = 1'b1; i_address = 32'h0000_0040;
    tick(3);
    drive_mem(3, 3, 1'b0);
    settle_check();
    check_eq("t1_cmd", {pmem_read, pmem_write, pmem_address}, {2'b10, 32'h40});
    advance();
    tick(3);
    tick(3);
    drive_mem(3, 3, 1'b0);
    pmem_rdata = {8{32'hAAAA_AAAA}};
    settle_check();
    check_eq("t1_resp", {i_resp, d_resp}, 2'b10);
    check_eq("t1_rdata", i_rdata, {8{32'hAAAA_AAAA}});
    advance();
    i_read = 1'b0;
    tick(3);
    tick(3);
    check_eq("t1_i_pulses", i_pulses, 1);
    check_eq("t1_d_pulses", d_pulses, 0);

    // Single D write-back to 0x100
    d_pulses = 0;
    d_write = 1'b1; d_address = 32'h100; d_wdata = {8{32'h1234_5678}};
    tick(2);
    drive_mem(2, 2, 1'b0);
    settle_check();
    check_eq("t2_cmd", {pmem_read, pmem_write}, 2'b01);
    check_eq("t2_wdata", pmem_wdata, {8{32'h1234_5678}});
    advance();
    tick(2);
    drive_mem(2, 2, 1'b0);
    settle_check();
    check_eq("t2_resp", {pmem_resp, d_resp}, 2'b11);
    advance();
    d_write = 1'b0;
    tick(2);
    check_eq("t2_d_pulses", d_pulses, 1);

    // Read and write raised together: only the write reaches memory
    d_read = 1'b1; d_write = 1'b1; d_address = 32'h180; d_wdata = rand_line();
    tick(1);
    drive_mem(1, 1, 1'b0);
    settle_check();
    check_eq("t4_rw", {pmem_read, pmem_write}, 2'b01);
    advance();
    tick(1);
    d_read = 1'b0; d_write = 1'b0;
    tick(1);

    // Both requesters held after reset: D, I, D, I
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    grant_q.delete();
    i_read = 1'b1; i_address = 32'h1000;
    d_read = 1'b1; d_address = 32'h2000;
    for (int n = 0; n < 30; n++) tick(2);
    i_read = 1'b0; d_read = 1'b0;
    tick(2);
    tick(2);
    check_eq("t3_grants", grant_q.size() >= 4, 1'b1);
    if (grant_q.size() >= 4) begin
      check_eq("t3_g0", grant_q[0], 32'h2000);
      check_eq("t3_g1", grant_q[1], 32'h1000);
      check_eq("t3_g2", grant_q[2], 32'h2000);
      check_eq("t3_g3", grant_q[3], 32'h1000);
    end

    // Abort: I withdraws mid-transaction, a pending D is granted from the next IDLE
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    i_pulses = 0;
    i_read = 1'b1; i_address = 32'h300;
    tick(5);
    tick(5);
    i_read = 1'b0;
    d_read = 1'b1; d_address = 32'h400;
    drive_mem(5, 5, 1'b0);
    settle_check();
    check_eq("t5_abort", {pmem_read, i_resp}, 2'b00);
    advance();
    drive_mem(2, 2, 1'b0);
    settle_check();
    check_eq("t5_idle", pmem_read, 1'b0);
    advance();
    drive_mem(2, 2, 1'b0);
    settle_check();
    check_eq("t5_d_grant", {pmem_read, pmem_address}, {1'b1, 32'h400});
    advance();
    tick(2);
    tick(2);
    d_read = 1'b0;
    tick(2);
    check_eq("t5_i_pulses", i_pulses, 0);

    // Asynchronous reset in the middle of a D transaction
    d_write = 1'b1; d_address = 32'h500; d_wdata = rand_line();
    tick(4);
    tick(4);
    reset = 1'b1;
    drive_mem(4, 4, 1'b0);
    settle_check();
    check_eq("t6_rst_cmd", {pmem_read, pmem_write, i_resp, d_resp}, 4'b0000);
    check_eq("t6_rst_wdata", pmem_wdata, 256'h0);
    advance();
    reset = 1'b0;
    d_write = 1'b0; d_read = 1'b1; d_address = 32'h600;
    i_read = 1'b1; i_address = 32'h700;
    tick(1);
    drive_mem(1, 1, 1'b0);
    settle_check();
    check_eq("t6_tie_d", {pmem_read, pmem_address}, {1'b1, 32'h600});
    advance();
    tick(1);
    d_read = 1'b0; i_read = 1'b0;
    tick(1);
    pmem_resp = 1'b1;
    settle_check();
    check_eq("t6_stray", {i_resp, d_resp}, 2'b00);
    advance();
    tick(1);

    // Randomized traffic with random latency, stray responses and occasional resets
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(149, 0) == 0);
      rand_inputs();
      drive_mem(1, 4, 1'b1);
      settle_check();
      advance();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
